// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage -- memory-access stage of the LoongArch32 5-stage pipeline.
// It holds one instruction between EX and WB, waits for the data-SRAM
// response of loads issued in EX, aligns and extends the load data, and
// buffers that data while WB applies backpressure. It also gives the decode
// stage forwarding and stall information.
//
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   ms_allowin             MS can accept an instruction this cycle
//   es_to_ms_valid/_bus    instruction from EX
//   ws_allowin             WB can accept
//   ms_to_ws_valid/_bus    completed instruction towards WB
//   data_sram_data_ok      one-cycle pulse: read data returned
//   data_sram_rdata        read data, valid while data_ok=1
//   ms_to_ds_dest/_result  forwarding towards decode
//   ms_to_ds_stall         decode must wait for the MS result
//
// Build option:
//   MS_LOAD_BYPASS_EN      when defined, load data is forwarded to decode in
//                          the cycle it returns (or from the buffer);
//                          otherwise any load in MS stalls decode.
// ---------------------------------------------------------------------------
module mem_stage #(
  parameter int unsigned ES_TO_MS_BUS_WD = 76,
  parameter int unsigned MS_TO_WS_BUS_WD = 71
) (
  input  logic                       clk,
  input  logic                       resetn,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  input  logic                       ws_allowin,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  output logic [4:0]                 ms_to_ds_dest,
  output logic [31:0]                ms_to_ds_result,
  output logic                       ms_to_ds_stall
);

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;

  // Pipeline and load-buffer state
  logic                       r_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] r_es_bus;
  logic                       r_buf_valid;
  logic [31:0]                r_buf;

  // Fields of the latched EX bus
  logic        w_res_from_mem;
  logic [1:0]  w_mem_size;
  logic        w_mem_unsigned;
  logic        w_gr_we;
  logic [4:0]  w_dest;
  logic [31:0] w_alu_result;
  logic [31:0] w_pc;
  logic        w_no_dest;
  logic        w_req_issued;

  assign w_res_from_mem = r_es_bus[75];
  assign w_mem_size     = r_es_bus[74:73];
  assign w_mem_unsigned = r_es_bus[72];
  assign w_gr_we        = r_es_bus[71];
  assign w_dest         = r_es_bus[70:66];
  assign w_alu_result   = r_es_bus[65:34];
  assign w_pc           = r_es_bus[33:2];
  assign w_no_dest      = r_es_bus[1];
  assign w_req_issued   = r_es_bus[0];

  // Handshake: a load with an outstanding request completes on data_ok or
  // once its data has been parked in the buffer.
  logic w_need_data;
  logic w_ready_go;
  logic w_handoff;
  logic w_buf_set;

  assign w_need_data    = w_res_from_mem & w_req_issued;
  assign w_ready_go     = !w_need_data || data_sram_data_ok || r_buf_valid;
  assign ms_to_ws_valid = r_ms_valid && w_ready_go;
  assign ms_allowin     = !r_ms_valid || (w_ready_go && ws_allowin);
  assign w_handoff      = ms_to_ws_valid && ws_allowin;
  // data_ok is only meaningful for the waiting load and only once
  assign w_buf_set      = r_ms_valid && w_need_data && data_sram_data_ok &&
                          !r_buf_valid && !ws_allowin;

  // Load alignment and extension
  logic [31:0] w_load_src;
  logic [31:0] w_load_shifted;
  logic [31:0] w_load_data;
  logic [31:0] w_final_result;

  assign w_load_src     = r_buf_valid ? r_buf : data_sram_rdata;
  assign w_load_shifted = w_load_src >> {w_alu_result[1:0], 3'b000};

  always_comb begin
    w_load_data = w_load_src;
    case (w_mem_size)
      SIZE_BYTE: w_load_data = {{24{!w_mem_unsigned && w_load_shifted[7]}},
                                w_load_shifted[7:0]};
      SIZE_HALF: w_load_data = {{16{!w_mem_unsigned && w_load_shifted[15]}},
                                w_load_shifted[15:0]};
      default:   w_load_data = w_load_src;
    endcase
  end

  assign w_final_result = w_res_from_mem ? w_load_data : w_alu_result;

  assign ms_to_ws_bus = {w_gr_we, w_dest, w_final_result, w_pc, w_no_dest};

  // Forwarding towards decode
  logic w_data_avail;
`ifdef MS_LOAD_BYPASS_EN
  assign w_data_avail = data_sram_data_ok || r_buf_valid;
`else
  assign w_data_avail = 1'b0;
`endif

  assign ms_to_ds_dest   = w_dest & {5{r_ms_valid && !w_no_dest && w_gr_we}};
  assign ms_to_ds_result = w_final_result;
  assign ms_to_ds_stall  = r_ms_valid && w_res_from_mem && w_gr_we &&
                           !w_no_dest && !w_data_avail;

  // Pipeline register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ms_valid <= 1'b0;
      r_es_bus   <= '0;
    end else begin
      if (ms_allowin) begin
        r_ms_valid <= es_to_ms_valid;
      end
      if (es_to_ms_valid && ms_allowin) begin
        r_es_bus <= es_to_ms_bus;
      end
    end
  end

  // Load data buffer: holds returned data while WB is stalled
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_buf_valid <= 1'b0;
      r_buf       <= '0;
    end else begin
      if (w_handoff) begin
        r_buf_valid <= 1'b0;
      end else if (w_buf_set) begin
        r_buf_valid <= 1'b1;
        r_buf       <= data_sram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage -- self-checking bench for mem_stage. Directed scenarios check
// fixed expected values; a randomized run compares every cycle against a
// transaction-level model (one held instruction plus an optional parked
// load value) kept in the bench.
// ---------------------------------------------------------------------------
module tb_mem_stage;

`ifdef MS_LOAD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic        rfm;
    logic [1:0]  size;
    logic        uns;
    logic        we;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic [31:0] pc;
    logic        nd;
    logic        req;
  } inst_t;

  logic        clk;
  logic        resetn;
  logic        ms_allowin;
  logic        ev;
  logic [75:0] es_bus;
  logic        ws;
  logic        ms_to_ws_valid;
  logic [70:0] ms_to_ws_bus;
  logic        dok;
  logic [31:0] rd;
  logic [4:0]  ms_to_ds_dest;
  logic [31:0] ms_to_ds_result;
  logic        ms_to_ds_stall;

  int total = 0;
  int bad   = 0;

  inst_t cur_inst;

  mem_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .ms_allowin        (ms_allowin),
    .es_to_ms_valid    (ev),
    .es_to_ms_bus      (es_bus),
    .ws_allowin        (ws),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .data_sram_data_ok (dok),
    .data_sram_rdata   (rd),
    .ms_to_ds_dest     (ms_to_ds_dest),
    .ms_to_ds_result   (ms_to_ds_result),
    .ms_to_ds_stall    (ms_to_ds_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic inst_t mk(input logic rfm, input logic [1:0] size,
                               input logic uns, input logic we,
                               input logic [4:0] dest, input logic [31:0] alu,
                               input logic [31:0] pc, input logic nd,
                               input logic req);
    inst_t i;
    i.rfm = rfm; i.size = size; i.uns = uns; i.we = we; i.dest = dest;
    i.alu = alu; i.pc = pc; i.nd = nd; i.req = req;
    return i;
  endfunction

  function automatic logic [75:0] pack(input inst_t i);
    return {i.rfm, i.size, i.uns, i.we, i.dest, i.alu, i.pc, i.nd, i.req};
  endfunction

  // Load value from the architectural rules: pick the addressed byte/half,
  // then sign- or zero-extend by arithmetic.
  function automatic logic [31:0] ext_load(input logic [31:0] src,
                                           input logic [1:0] size,
                                           input logic uns,
                                           input logic [1:0] off);
    longint v;
    if (size == 2'd0) begin
      v = (longint'(src) / (longint'(1) << (8 * int'(off)))) % 256;
      if (!uns && v >= 128) v = v - 256;
    end else if (size == 2'd1) begin
      v = (longint'(src) / (longint'(1) << (8 * int'(off)))) % 65536;
      if (!uns && v >= 32768) v = v - 65536;
    end else begin
      v = longint'(src);
    end
    return 32'(v);
  endfunction

  // Reference model: the instruction held in MS and any parked load value
  bit          m_valid;
  inst_t       m_inst;
  bit          m_has_buf;
  logic [31:0] m_buf;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_valid   = 1'b0;
      m_has_buf = 1'b0;
      m_buf     = '0;
    end else begin
      bit waiting, done, leaves;
      waiting = m_valid && m_inst.rfm && m_inst.req;
      done    = !(m_inst.rfm && m_inst.req) || dok || m_has_buf;
      leaves  = m_valid && done && ws;
      if (leaves) m_has_buf = 1'b0;
      else if (waiting && dok && !m_has_buf && !ws) begin
        m_has_buf = 1'b1;
        m_buf     = rd;
      end
      if (!m_valid || leaves) begin
        m_valid = ev;
        if (ev) m_inst = cur_inst;
      end
    end
  end

  task automatic drive(input logic v, input inst_t i, input logic w,
                       input logic d, input logic [31:0] r);
    @(negedge clk);
    ev = v; cur_inst = i; es_bus = pack(i); ws = w; dok = d; rd = r;
    #1;
  endtask

  task automatic test_reset();
    total++; if (ms_allowin !== 1'b1) begin bad++; $display("FAIL reset_allowin got=%b exp=1", ms_allowin); end
    total++; if (ms_to_ws_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", ms_to_ws_valid); end
    total++; if (ms_to_ds_dest !== 5'd0) begin bad++; $display("FAIL reset_dest got=%0d exp=0", ms_to_ds_dest); end
    total++; if (ms_to_ds_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", ms_to_ds_stall); end
  endtask

  task automatic test_alu();
    inst_t a;
    a = mk(1'b0, 2'd2, 1'b0, 1'b1, 5'd5, 32'h12345678, 32'h1c000000, 1'b0, 1'b0);
    drive(1'b1, a, 1'b1, 1'b0, 32'h0);
    total++; if (ms_allowin !== 1'b1) begin bad++; $display("FAIL alu_allowin got=%b exp=1", ms_allowin); end
    drive(1'b0, a, 1'b1, 1'b0, 32'h0);
    total++; if (ms_to_ws_valid !== 1'b1) begin bad++; $display("FAIL alu_valid got=%b exp=1", ms_to_ws_valid); end
    total++; if (ms_to_ws_bus !== {1'b1, 5'd5, 32'h12345678, 32'h1c000000, 1'b0}) begin bad++; $display("FAIL alu_bus got=%h exp=%h", ms_to_ws_bus, {1'b1, 5'd5, 32'h12345678, 32'h1c000000, 1'b0}); end
    total++; if (ms_to_ds_dest !== 5'd5) begin bad++; $display("FAIL alu_dest got=%0d exp=5", ms_to_ds_dest); end
    total++; if (ms_to_ds_stall !== 1'b0) begin bad++; $display("FAIL alu_stall got=%b exp=0", ms_to_ds_stall); end
    drive(1'b0, a, 1'b1, 1'b0, 32'h0);
    total++; if (ms_to_ws_valid !== 1'b0) begin bad++; $display("FAIL alu_gone got=%b exp=0", ms_to_ws_valid); end
  endtask

  task automatic test_load_ext();
    inst_t l;
    l = mk(1'b1, 2'd0, 1'b0, 1'b1, 5'd7, 32'h00001003, 32'h1c000010, 1'b0, 1'b1);
    drive(1'b1, l, 1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, l, 1'b1, 1'b0, 32'h0);
      total++; if (ms_to_ws_valid !== 1'b0) begin bad++; $display("FAIL ldb_wait%0d got=%b exp=0", k, ms_to_ws_valid); end
      total++; if (ms_to_ds_stall !== 1'b1) begin bad++; $display("FAIL ldb_wait_stall%0d got=%b exp=1", k, ms_to_ds_stall); end
      total++; if (ms_to_ds_dest !== 5'd7) begin bad++; $display("FAIL ldb_dest%0d got=%0d exp=7", k, ms_to_ds_dest); end
    end
    drive(1'b0, l, 1'b1, 1'b1, 32'h80FFFFFF);
    total++; if (ms_to_ws_valid !== 1'b1) begin bad++; $display("FAIL ldb_valid got=%b exp=1", ms_to_ws_valid); end
    total++; if (ms_to_ws_bus[64:33] !== 32'hFFFFFF80) begin bad++; $display("FAIL ldb_result got=%h exp=ffffff80", ms_to_ws_bus[64:33]); end
    total++; if (ms_to_ds_result !== 32'hFFFFFF80) begin bad++; $display("FAIL ldb_fwd got=%h exp=ffffff80", ms_to_ds_result); end
    total++; if (ms_to_ds_stall !== !BYP) begin bad++; $display("FAIL ldb_stall got=%b exp=%b", ms_to_ds_stall, !BYP); end

    l.uns = 1'b1;
    drive(1'b1, l, 1'b1, 1'b0, 32'h0);
    drive(1'b0, l, 1'b1, 1'b1, 32'h80FFFFFF);
    total++; if (ms_to_ws_valid !== 1'b1) begin bad++; $display("FAIL ldbu_valid got=%b exp=1", ms_to_ws_valid); end
    total++; if (ms_to_ws_bus[64:33] !== 32'h00000080) begin bad++; $display("FAIL ldbu_result got=%h exp=00000080", ms_to_ws_bus[64:33]); end

    l = mk(1'b1, 2'd1, 1'b0, 1'b1, 5'd8, 32'h00001002, 32'h1c000014, 1'b0, 1'b1);
    drive(1'b1, l, 1'b1, 1'b0, 32'h0);
    drive(1'b0, l, 1'b1, 1'b1, 32'h7FFF0000);
    total++; if (ms_to_ws_bus[64:33] !== 32'h00007FFF) begin bad++; $display("FAIL ldh_result got=%h exp=00007fff", ms_to_ws_bus[64:33]); end

    l = mk(1'b1, 2'd1, 1'b0, 1'b1, 5'd8, 32'h00001000, 32'h1c000018, 1'b0, 1'b1);
    drive(1'b1, l, 1'b1, 1'b0, 32'h0);
    drive(1'b0, l, 1'b1, 1'b1, 32'h12348001);
    total++; if (ms_to_ws_bus[64:33] !== 32'hFFFF8001) begin bad++; $display("FAIL ldh_neg got=%h exp=ffff8001", ms_to_ws_bus[64:33]); end

    l = mk(1'b1, 2'd2, 1'b0, 1'b1, 5'd9, 32'h00001000, 32'h1c00001c, 1'b0, 1'b1);
    drive(1'b1, l, 1'b1, 1'b0, 32'h0);
    drive(1'b0, l, 1'b1, 1'b1, 32'h7FFF0000);
    total++; if (ms_to_ws_bus[64:33] !== 32'h7FFF0000) begin bad++; $display("FAIL ldw_result got=%h exp=7fff0000", ms_to_ws_bus[64:33]); end
    drive(1'b0, l, 1'b1, 1'b0, 32'h0);
  endtask

  task automatic test_buffer();
    inst_t b;
    b = mk(1'b1, 2'd2, 1'b0, 1'b1, 5'd9, 32'h00002000, 32'h1c000020, 1'b0, 1'b1);
    drive(1'b1, b, 1'b0, 1'b0, 32'h0);
    drive(1'b0, b, 1'b0, 1'b1, 32'hDEADBEEF);
    total++; if (ms_to_ws_valid !== 1'b1) begin bad++; $display("FAIL buf_first_valid got=%b exp=1", ms_to_ws_valid); end
    total++; if (ms_allowin !== 1'b0) begin bad++; $display("FAIL buf_first_allowin got=%b exp=0", ms_allowin); end
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, b, 1'b0, 1'b0, 32'h0);
      total++; if (ms_to_ws_valid !== 1'b1) begin bad++; $display("FAIL buf_hold_valid%0d got=%b exp=1", k, ms_to_ws_valid); end
      total++; if (ms_to_ws_bus[64:33] !== 32'hDEADBEEF) begin bad++; $display("FAIL buf_hold_data%0d got=%h exp=deadbeef", k, ms_to_ws_bus[64:33]); end
      total++; if (ms_allowin !== 1'b0) begin bad++; $display("FAIL buf_hold_allowin%0d got=%b exp=0", k, ms_allowin); end
      total++; if (ms_to_ds_stall !== !BYP) begin bad++; $display("FAIL buf_hold_stall%0d got=%b exp=%b", k, ms_to_ds_stall, !BYP); end
    end
    drive(1'b0, b, 1'b1, 1'b0, 32'h0);
    total++; if (ms_to_ws_bus[64:33] !== 32'hDEADBEEF) begin bad++; $display("FAIL buf_release_data got=%h exp=deadbeef", ms_to_ws_bus[64:33]); end
    total++; if (ms_allowin !== 1'b1) begin bad++; $display("FAIL buf_release_allowin got=%b exp=1", ms_allowin); end
    // a later load must wait for its own data: the buffer is empty again
    b = mk(1'b1, 2'd2, 1'b0, 1'b1, 5'd10, 32'h00002004, 32'h1c000024, 1'b0, 1'b1);
    drive(1'b1, b, 1'b1, 1'b0, 32'h0);
    drive(1'b0, b, 1'b1, 1'b0, 32'h0);
    total++; if (ms_to_ws_valid !== 1'b0) begin bad++; $display("FAIL buf_cleared got=%b exp=0", ms_to_ws_valid); end
    drive(1'b0, b, 1'b1, 1'b1, 32'h11223344);
    total++; if (ms_to_ws_bus[64:33] !== 32'h11223344) begin bad++; $display("FAIL buf_next_data got=%h exp=11223344", ms_to_ws_bus[64:33]); end
    drive(1'b0, b, 1'b1, 1'b0, 32'h0);
  endtask

  task automatic test_back_to_back();
    inst_t a1, a2, l;
    a1 = mk(1'b0, 2'd0, 1'b0, 1'b1, 5'd1, 32'hAAAA0001, 32'h1c000100, 1'b0, 1'b0);
    a2 = mk(1'b0, 2'd0, 1'b0, 1'b1, 5'd2, 32'hBBBB0002, 32'h1c000104, 1'b0, 1'b0);
    l  = mk(1'b1, 2'd0, 1'b0, 1'b1, 5'd3, 32'h00003001, 32'h1c000108, 1'b0, 1'b1);
    drive(1'b1, a1, 1'b1, 1'b0, 32'h0);
    drive(1'b1, a2, 1'b1, 1'b0, 32'h0);
    total++; if (ms_to_ws_bus[64:33] !== 32'hAAAA0001 || ms_allowin !== 1'b1) begin bad++; $display("FAIL b2b_first got=%h/%b exp=aaaa0001/1", ms_to_ws_bus[64:33], ms_allowin); end
    drive(1'b1, l, 1'b1, 1'b0, 32'h0);
    total++; if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[64:33] !== 32'hBBBB0002) begin bad++; $display("FAIL b2b_second got=%b/%h exp=1/bbbb0002", ms_to_ws_valid, ms_to_ws_bus[64:33]); end
    drive(1'b0, l, 1'b1, 1'b1, 32'h0000F100);
    total++; if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[64:33] !== 32'hFFFFFFF1) begin bad++; $display("FAIL b2b_load got=%b/%h exp=1/fffffff1", ms_to_ws_valid, ms_to_ws_bus[64:33]); end
    drive(1'b0, l, 1'b1, 1'b0, 32'h0);
    total++; if (ms_to_ws_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", ms_to_ws_valid); end
  endtask

  task automatic test_reset_mid_load();
    inst_t l, a;
    l = mk(1'b1, 2'd2, 1'b0, 1'b1, 5'd7, 32'h00004000, 32'h1c000200, 1'b0, 1'b1);
    a = mk(1'b0, 2'd0, 1'b0, 1'b1, 5'd4, 32'hCAFE0004, 32'h1c000204, 1'b0, 1'b0);
    drive(1'b1, l, 1'b1, 1'b0, 32'h0);
    drive(1'b0, l, 1'b1, 1'b0, 32'h0);
    total++; if (ms_to_ds_stall !== 1'b1) begin bad++; $display("FAIL rml_pending_stall got=%b exp=1", ms_to_ds_stall); end
    @(negedge clk); resetn = 1'b0; #1;
    total++; if (ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b1) begin bad++; $display("FAIL rml_in_reset got=%b/%b exp=0/1", ms_to_ws_valid, ms_allowin); end
    total++; if (ms_to_ds_dest !== 5'd0 || ms_to_ds_stall !== 1'b0) begin bad++; $display("FAIL rml_fwd got=%0d/%b exp=0/0", ms_to_ds_dest, ms_to_ds_stall); end
    @(negedge clk); resetn = 1'b1;
    drive(1'b0, l, 1'b1, 1'b1, 32'hAAAA5555);
    total++; if (ms_to_ws_valid !== 1'b0 || ms_to_ds_dest !== 5'd0) begin bad++; $display("FAIL rml_stray_ok got=%b/%0d exp=0/0", ms_to_ws_valid, ms_to_ds_dest); end
    drive(1'b1, a, 1'b1, 1'b0, 32'h0);
    drive(1'b0, a, 1'b1, 1'b0, 32'h0);
    total++; if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[64:33] !== 32'hCAFE0004) begin bad++; $display("FAIL rml_after got=%b/%h exp=1/cafe0004", ms_to_ws_valid, ms_to_ws_bus[64:33]); end
  endtask

  task automatic test_random();
    inst_t r;
    logic [31:0] e_final;
    logic [4:0]  e_dest;
    bit          waits, have, e_valid, e_allow, e_stall;
    for (int n = 0; n < 1500; n++) begin
      r = mk(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 5'($urandom), $urandom, $urandom,
             1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0));
      if (r.size == 2'd1) r.alu[0] = 1'b0;
      drive(1'($urandom_range(0, 1)), r, 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 2) == 0), $urandom);
      waits   = m_inst.rfm && m_inst.req;
      have    = !waits || dok || m_has_buf;
      e_valid = m_valid && have;
      e_allow = !m_valid || (have && ws);
      e_final = m_inst.rfm ? ext_load(m_has_buf ? m_buf : rd, m_inst.size, m_inst.uns, m_inst.alu[1:0])
                           : m_inst.alu;
      e_dest  = (m_valid && !m_inst.nd && m_inst.we) ? m_inst.dest : 5'd0;
      e_stall = m_valid && m_inst.rfm && m_inst.we && !m_inst.nd && !(BYP && (dok || m_has_buf));
      total++; if (ms_to_ws_valid !== e_valid) begin bad++; $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, ms_to_ws_valid, e_valid); end
      total++; if (ms_allowin !== e_allow) begin bad++; $display("FAIL rnd_allowin n=%0d got=%b exp=%b", n, ms_allowin, e_allow); end
      total++; if (ms_to_ds_dest !== e_dest) begin bad++; $display("FAIL rnd_dest n=%0d got=%0d exp=%0d", n, ms_to_ds_dest, e_dest); end
      total++; if (ms_to_ds_stall !== e_stall) begin bad++; $display("FAIL rnd_stall n=%0d got=%b exp=%b", n, ms_to_ds_stall, e_stall); end
      if (e_valid) begin
        total++;
        if (ms_to_ws_bus !== {m_inst.we, m_inst.dest, e_final, m_inst.pc, m_inst.nd}) begin
          bad++;
          $display("FAIL rnd_bus n=%0d got=%h exp=%h", n, ms_to_ws_bus,
                   {m_inst.we, m_inst.dest, e_final, m_inst.pc, m_inst.nd});
        end
        total++; if (ms_to_ds_result !== e_final) begin bad++; $display("FAIL rnd_fwd n=%0d got=%h exp=%h", n, ms_to_ds_result, e_final); end
      end
    end
  endtask

  initial begin
    resetn   = 1'b0;
    ev       = 1'b0;
    ws       = 1'b1;
    dok      = 1'b0;
    rd       = '0;
    cur_inst = mk(1'b0, 2'd0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    es_bus   = pack(cur_inst);
    repeat (2) @(negedge clk);
    #1;
    test_reset();
    @(negedge clk);
    resetn = 1'b1;
    test_alu();
    test_load_ext();
    test_buffer();
    test_back_to_back();
    test_reset_mid_load();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage LoongArch32 pipeline, sitting between the execute stage (ES) and the write-back stage (WS).
- Drives the MS→WS bus and valid signal, and obeys WS backpressure via `ws_allowin`.
- Waits for the data-SRAM response of loads issued in EX, aligns and sign/zero-extends the load data, and buffers it when WS stalls.
- Supplies forwarding and stall information to the decode stage (DS).

Parameters:
- ES_TO_MS_BUS_WD, 76, width of the ES→MS bus.
- MS_TO_WS_BUS_WD, 71, width of the MS→WS bus.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous reset, active low.
- ms_allowin  out  1  MS can accept a new instruction this cycle.
- es_to_ms_valid  in  1  ES presents a valid instruction.
- es_to_ms_bus  in  76  [75] res_from_mem, [74:73] mem_size (00 byte, 01 half, 10 word), [72] mem_unsigned, [71] gr_we, [70:66] dest, [65:34] alu_result, [33:2] pc, [1] inst_no_dest, [0] req_issued.
- ws_allowin  in  1  WS can accept.
- ms_to_ws_valid  out  1  MS presents a completed instruction.
- ms_to_ws_bus  out  71  [70] gr_we, [69:65] dest, [64:33] final_result, [32:1] pc, [0] inst_no_dest.
- data_sram_data_ok  in  1  one-cycle pulse: read data returned.
- data_sram_rdata  in  32  read data, valid when data_ok=1.
- ms_to_ds_dest  out  5  destination register of the valid MS instruction; 0 if MS is invalid or the instruction has no destination.
- ms_to_ds_result  out  32  value forwarded to DS.
- ms_to_ds_stall  out  1  DS must stall: MS destination value not yet available.

Behaviour:
- Reset (async on resetn=0):
  - ms_valid=0, data_buf_valid=0, data_buf=0, bus register=0.
  - Consequently ms_to_ws_valid=0, ms_to_ds_dest=0, ms_to_ds_stall=0, ms_allowin=1.
- Pipeline register:
  - ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
  - When ms_allowin, ms_valid <= es_to_ms_valid.
  - The bus is latched only when es_to_ms_valid && ms_allowin.
- need_data = res_from_mem && req_issued.
  - ms_ready_go = !need_data || data_ok || data_buf_valid.
  - ms_to_ws_valid = ms_valid && ms_ready_go.
- Data buffer:
  - Set when ms_valid && need_data && data_ok && !ws_allowin; data_buf <= rdata.
  - Cleared when ms_to_ws_valid && ws_allowin.
  - data_ok is ignored while ms_valid=0 or data_buf_valid=1.
- Load data source: data_buf if data_buf_valid, else data_sram_rdata. Shift right by 8*alu_result[1:0].
  - byte: bits[7:0]; sign-extended unless mem_unsigned.
  - half: bits[15:0]; alu_result[0] is always 0; extension as for byte.
  - word: all 32 bits, no shift.
- final_result = res_from_mem ? load_data : alu_result. Remaining MS→WS fields pass through unchanged.
- Back-to-back: the same cycle that hands off to WS may latch the next ES instruction. Zero bubbles for non-loads and for loads whose data_ok arrives in their first MS cycle.
- Simultaneous data_ok and ws_allowin=1: the result passes straight through and the buffer is not set.
- Load stalled in MS for N cycles: ms_to_ws_valid stays 0 until data_ok, then holds with a stable bus until ws_allowin.
- Reset mid-load: any in-flight data is discarded. A data_ok arriving after reset with ms_valid=0 is ignored.
- Forwarding:
  - ms_to_ds_dest = dest & {5{ms_valid && !inst_no_dest && gr_we}}.
  - ms_to_ds_result = final_result.
- ms_to_ds_stall = ms_valid && res_from_mem && gr_we && !inst_no_dest && !(data available this cycle, per the feature below).

Optional Feature:
- Macro: MS_LOAD_BYPASS_EN.
- Defined: "data available" = data_ok || data_buf_valid. The load value is forwarded from MS as soon as it returns.
- Undefined: "data available" is always false. Any load in MS raises ms_to_ds_stall until it leaves MS; DS then picks the value up from WS.

Test Plan:
- ALU instruction (pc=0x1c000000, dest=5, alu_result=0x12345678, res_from_mem=0), ws_allowin=1 → next cycle ms_to_ws_valid=1, final_result=0x12345678, ms_to_ds_dest=5, stall=0.
- ld.b at alu_result=0x...03, rdata=0x80FFFFFF, data_ok 2 cycles late → ms_to_ws_valid=0 for 2 cycles, then final_result=0xFFFFFF80. With mem_unsigned=1 → 0x00000080.
- ld.h at offset 2, rdata=0x7FFF0000 → 0x00007FFF. ld.w at offset 0 → 0x7FFF0000.
- data_ok arrives with ws_allowin=0 for 3 cycles, rdata=0xDEADBEEF, then changes to 0 → bus holds final_result=0xDEADBEEF; handed over on the first ws_allowin=1; buffer cleared.
- Load in MS with dest=7, data_ok pending → stall=1. With MS_LOAD_BYPASS_EN: stall=0 in the data_ok cycle and ms_to_ds_result=the load data. Without the macro: stall=1 until the load leaves MS.
- resetn pulsed low while a load waits → ms_valid=0 immediately; a following data_ok is ignored; the next ALU instruction completes normally.
